// File: rtl/rvm_mdu_pkg.sv
// Shared encodings and helpers for the RV32M iterative multiply/divide unit.
// Op and FSM state encodings, op-class decode and the wide negate used in sign fix-up.
package rvm_mdu_pkg;

  typedef enum logic [3:0] {
    RVM_MDU_NOP    = 4'd0,
    RVM_MDU_MUL    = 4'd1,
    RVM_MDU_MULH   = 4'd2,
    RVM_MDU_MULHSU = 4'd3,
    RVM_MDU_MULHU  = 4'd4,
    RVM_MDU_DIV    = 4'd5,
    RVM_MDU_DIVU   = 4'd6,
    RVM_MDU_REM    = 4'd7,
    RVM_MDU_REMU   = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    RVM_MDU_IDLE = 2'd0,
    RVM_MDU_BUSY = 2'd1,
    RVM_MDU_DONE = 2'd2
  } mdu_state_e;

  // Encodings 9-15 are reserved and behave exactly like NOP.
  function automatic logic op_is_nop(input logic [3:0] o);
    return (o == 4'd0) || (o > 4'd8);
  endfunction

  function automatic logic op_is_div(input logic [3:0] o);
    return (o >= 4'd5) && (o <= 4'd8);
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/rvm_mdu_addsub.sv
// 33-bit adder/subtractor shared by multiply-accumulate and divide trial-subtract.
// Purely combinational; no flow control.
module rvm_mdu_addsub (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] y
);

  assign y = a + (b ^ {33{sub}}) + {32'd0, sub};

endmodule

// File: rtl/rvm_mdu.sv
// Iterative RV32M multiply/divide: 32 shift-add/shift-subtract cycles, divide-by-zero in one.
// Core holds op until valid; op back to NOP releases DONE or aborts BUSY with no result.
module rvm_mdu
  import rvm_mdu_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [3:0]  op,
  output logic        valid,
  output logic [31:0] result
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic        lhs_neg_q, lhs_neg_d;
  logic        rhs_neg_q, rhs_neg_d;
  logic [31:0] result_q, result_d;

  logic        in_lneg, in_rneg;
  logic [31:0] lhs_mag, rhs_mag;
  logic [32:0] as_a, as_b, as_y;
  logic        as_sub;
  logic [32:0] mul_hi;
  logic [63:0] step_acc, prod_fix;
  logic [31:0] quot_fix, rem_fix, fin_res;

  assign in_lneg = lhs[31] && (op == RVM_MDU_MULH || op == RVM_MDU_MULHSU ||
                               op == RVM_MDU_DIV  || op == RVM_MDU_REM);
  assign in_rneg = rhs[31] && (op == RVM_MDU_MULH || op == RVM_MDU_DIV ||
                               op == RVM_MDU_REM);
  assign lhs_mag = in_lneg ? 32'd0 - lhs : lhs;
  assign rhs_mag = in_rneg ? 32'd0 - rhs : rhs;

  rvm_mdu_addsub u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y)
  );

  // acc holds {product_hi, multiplier} when multiplying and {rem, quot} when dividing.
  always_comb begin
    as_b   = {1'b0, mcand_q};
    as_a   = {1'b0, acc_q[63:32]};
    as_sub = 1'b0;
    mul_hi = {1'b0, acc_q[63:32]};
    if (op_is_div(op_q)) begin
      as_a   = {acc_q[63:32], acc_q[31]};
      as_sub = 1'b1;
      // Remainder stays below 2*divisor, so bit 32 of the difference is a reliable sign.
      if (!as_y[32]) step_acc = {as_y[31:0], acc_q[30:0], 1'b1};
      else           step_acc = {acc_q[62:0], 1'b0};
    end else begin
      if (acc_q[0]) mul_hi = as_y;
      step_acc = {mul_hi, acc_q[31:1]};
    end
  end

  always_comb begin
    prod_fix = (lhs_neg_q ^ rhs_neg_q) ? neg64(step_acc) : step_acc;
    quot_fix = (lhs_neg_q ^ rhs_neg_q) ? 32'd0 - step_acc[31:0] : step_acc[31:0];
    rem_fix  = lhs_neg_q ? 32'd0 - step_acc[63:32] : step_acc[63:32];
    case (op_q)
      RVM_MDU_MUL:                    fin_res = prod_fix[31:0];
      RVM_MDU_MULH, RVM_MDU_MULHSU,
      RVM_MDU_MULHU:                  fin_res = prod_fix[63:32];
      RVM_MDU_DIV, RVM_MDU_DIVU:      fin_res = quot_fix;
      RVM_MDU_REM, RVM_MDU_REMU:      fin_res = rem_fix;
      default:                        fin_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    lhs_neg_d = lhs_neg_q;
    rhs_neg_d = rhs_neg_q;
    result_d  = result_q;
    case (state_q)
      RVM_MDU_IDLE: begin
        if (!op_is_nop(op)) begin
          op_d      = op;
          lhs_neg_d = in_lneg;
          rhs_neg_d = in_rneg;
          cnt_d     = 5'd0;
          if (op_is_div(op)) begin
            acc_d   = {32'd0, lhs_mag};
            mcand_d = rhs_mag;
          end else begin
            acc_d   = {32'd0, rhs_mag};
            mcand_d = lhs_mag;
          end
          if (op_is_div(op) && rhs == 32'd0) begin
            result_d = (op == RVM_MDU_DIV || op == RVM_MDU_DIVU) ? 32'hFFFF_FFFF : lhs;
            state_d  = RVM_MDU_DONE;
          end else begin
            state_d = RVM_MDU_BUSY;
          end
        end
      end
      RVM_MDU_BUSY: begin
        if (op_is_nop(op)) begin
          state_d = RVM_MDU_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = fin_res;
            state_d  = RVM_MDU_DONE;
          end
        end
      end
      RVM_MDU_DONE: begin
        if (op_is_nop(op)) state_d = RVM_MDU_IDLE;
      end
      default: state_d = RVM_MDU_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= RVM_MDU_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 4'd0;
      acc_q     <= 64'd0;
      mcand_q   <= 32'd0;
      lhs_neg_q <= 1'b0;
      rhs_neg_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      lhs_neg_q <= lhs_neg_d;
      rhs_neg_q <= rhs_neg_d;
      result_q  <= result_d;
    end
  end

  assign valid  = (state_q == RVM_MDU_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rvm_mdu.sv
// Bench for rvm_mdu: directed RV32M cases, abort/reset scenarios and random ops
// checked against an arithmetic reference model.
module tb_rvm_mdu;

  localparam logic [3:0] OP_NOP = 4'd0, OP_MUL = 4'd1, OP_MULH = 4'd2, OP_MULHSU = 4'd3,
                         OP_MULHU = 4'd4, OP_DIV = 4'd5, OP_DIVU = 4'd6, OP_REM = 4'd7,
                         OP_REMU = 4'd8;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic [31:0] lhs, rhs;
  logic [3:0]  op;
  logic        valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  rvm_mdu dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .lhs      (lhs),
    .rhs      (rhs),
    .op       (op),
    .valid    (valid),
    .result   (result)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit and 32-bit arithmetic.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ub;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      OP_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Called just after a rising edge with op at NOP for at least the previous cycle.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    int exp_lat;
    logic [31:0] expv;
    expv    = model(o, a, b);
    exp_lat = (o >= OP_DIV && b == 32'd0) ? 1 : 33;
    op  = o;
    lhs = a;
    rhs = b;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge g_clk); #1;
      lhs = $urandom;
      rhs = $urandom;
      if (valid) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, {32'd0, result}, {32'd0, expv});
    @(posedge g_clk); #1;
    check({tag, " hold"}, {31'd0, valid, result}, {31'd0, 1'b1, expv});
    op = OP_NOP;
    @(posedge g_clk); #1;
    check({tag, " valid_fall"}, {63'd0, valid}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] pool [5];
    pool[0] = 32'd0;
    pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'h8000_0000;
    pool[3] = 32'd1;
    pool[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic seen;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    g_resetn = 1'b0;
    op  = OP_NOP;
    lhs = 32'd0;
    rhs = 32'd0;
    repeat (2) @(posedge g_clk);
    #1;
    check("reset valid", {63'd0, valid}, 64'd0);
    check("reset result", {32'd0, result}, 64'd0);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;

    // Reserved encodings must not start an operation.
    op = 4'd11;
    lhs = 32'd9;
    rhs = 32'd3;
    seen = 1'b0;
    repeat (40) begin
      @(posedge g_clk); #1;
      seen |= valid;
    end
    check("reserved op idle", {63'd0, seen}, 64'd0);
    op = OP_NOP;
    @(posedge g_clk); #1;

    run_op("mulhu max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh -2*3", OP_MULH, 32'hFFFF_FFFE, 32'd3);
    run_op("mulhsu -1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("divu by0", OP_DIVU, 32'd5, 32'd0);
    run_op("rem by0", OP_REM, 32'd5, 32'd0);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("remu", OP_REMU, 32'd1000, 32'd7);

    // Abort: op drops to NOP ten cycles after it was first presented.
    op  = OP_DIV;
    lhs = 32'd1000;
    rhs = 32'd3;
    repeat (10) @(posedge g_clk);
    #1;
    op = OP_NOP;
    seen = 1'b0;
    repeat (40) begin
      @(posedge g_clk); #1;
      seen |= valid;
    end
    check("abort no valid", {63'd0, seen}, 64'd0);
    run_op("divu after abort", OP_DIVU, 32'd100, 32'd7);

    // Asynchronous reset in the middle of BUSY.
    op  = OP_MUL;
    lhs = 32'd7;
    rhs = 32'd9;
    repeat (5) @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    #1;
    check("midbusy reset valid", {63'd0, valid}, 64'd0);
    check("midbusy reset result", {32'd0, result}, 64'd0);
    #2;
    op = OP_NOP;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    run_op("mul after reset", OP_MUL, 32'd7, 32'd9);

    for (int n = 0; n < 40; n++) begin
      ro = 4'($urandom_range(1, 8));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d op%0d %h %h", n, ro, ra, rb), ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvm_mdu.md
# rvm_mdu

Iterative multiply/divide unit for the RV32M extension. It uses the same `op`/`valid`/`result` contract as the core's single-cycle shifter, except that `valid` arrives after a multi-cycle shift-add or shift-subtract sequence. The unit sits beside the ALU and shifter in the execute stage. The core FSM holds `op` until `valid` and then reads `result`.

## Interface
- Parameters: none.
- `g_clk` in 1: clock, rising edge.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `lhs` in 32: rs1 operand (dividend or multiplicand).
- `rhs` in 32: rs2 operand (divisor or multiplier).
- `op` in 4: operation select. Encodings are `RVM_MDU_NOP=0`, `MUL=1`, `MULH=2`, `MULHSU=3`, `MULHU=4`, `DIV=5`, `DIVU=6`, `REM=7`, `REMU=8`. Values 9–15 are treated as NOP.
- `valid` out 1: `result` is complete.
- `result` out 32: operation result, registered.

## Operation
- **FSM states:** `IDLE`, `BUSY`, `DONE`.
- **IDLE**
  - `op==NOP`: stay in IDLE.
  - Otherwise, latch at the clock edge: operand magnitudes, sign flags, and the op.
  - Per-op signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats only `lhs` as signed. The other ops treat both as unsigned.
  - Clear the 5-bit iteration counter and go to BUSY.
  - Exception: divide ops with `rhs==0` go straight to DONE (see special cases).
- **BUSY, multiply**
  - 64-bit accumulator.
  - Each cycle: add the multiplicand to the high half if the multiplier LSB is set, then shift the {acc, multiplier} pair right by 1.
- **BUSY, divide**
  - Restoring division on magnitudes.
  - Each cycle: shift the {rem, quot} pair left by 1, trial-subtract the divisor from rem as a 33-bit operation, and keep the difference if it is non-negative (set quot LSB to 1).
- **BUSY exit:** after 32 iterations (counter wraps 31→0), go to DONE.
- **Sign fix-up on entry to DONE**
  - Negate the 64-bit product if the operand signs differ.
  - Quotient takes the sign of (dividend XOR divisor).
  - Remainder takes the sign of the dividend.
- **Result selection**
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- **Special cases**
  - Divide by zero: quotient 0xFFFFFFFF, remainder = `lhs`. Takes 1 cycle (IDLE→DONE).
  - Signed overflow (0x80000000 / −1): quotient 0x80000000, remainder 0. This falls out of the magnitude algorithm and must not be special-cased incorrectly.
- **DONE:** `valid=1` and `result` holds its value. When `op==NOP`, go to IDLE.
- **Op change while busy:** if `op` returns to NOP in BUSY, abort to IDLE with no result. If `op` changes to another non-NOP value in BUSY or DONE, behaviour is undefined. The core must hold `op` stable.
- **Gating:** operand registers load only in IDLE, so operand toggling in other states has no effect.

## Timing
- **Reset:** state=IDLE, `valid=0`, `result=0`, counter=0, all datapath registers 0.
- **Normal latency**
  - `op` first non-NOP in cycle N (sampled at the end of N).
  - BUSY occupies cycles N+1…N+32.
  - `valid=1` from cycle N+33 until the cycle after `op` returns to NOP.
- **Divide-by-zero latency:** `valid=1` in cycle N+1.
- **Back-to-back:** `op` must read NOP for at least one cycle between operations. `valid` falls in the cycle following the NOP.
- **Reset mid-operation:** `g_resetn` low at any time forces the reset values immediately (asynchronous). No partial result is visible.

## Structure
- Add the `RVM_MDU_*` op encodings to `rvm_constants.v`, alongside `RVM_SHIFT_*`.
- Add the FSM state encodings (`RVM_MDU_IDLE/BUSY/DONE`) locally or in the same constants file.
- Sub-module: `rvm_mdu_addsub`, a 33-bit add/subtract shared by the multiply-accumulate and divide trial-subtract paths.
- Sign fix-up uses a separate 64-bit negate in the top level.

## Test plan
- **Unsigned multiply:** MULHU lhs=0xFFFFFFFF, rhs=0xFFFFFFFF → `valid` at N+33, result=0xFFFFFFFE. The same operands with MUL → 0x00000001.
- **Signed multiply:** MULH lhs=0xFFFFFFFE (−2), rhs=3 → 0xFFFFFFFF. MULHSU lhs=−1, rhs=0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:** DIV lhs=−7, rhs=2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1).
- **Divide by zero:** DIVU lhs=5, rhs=0 → result=0xFFFFFFFF with `valid` at N+1. REM lhs=5, rhs=0 → 5.
- **Overflow:** DIV lhs=0x80000000, rhs=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- **Abort and reset:**
  - Drop `op` to NOP at N+10: `valid` never asserts, and a new DIVU 100/7 then returns 14.
  - Pulse `g_resetn` low mid-BUSY: `valid=0` and `result=0` immediately.
